// File: rtl/qtree_nat_serializer.sv
// Streams a quadtree stored in a 66-bit word heap as postfix-ordered AXI-stream beats.
// Uses an explicit frame stack; overflowing it latches err and parks in ERROR until reset.
module qtree_nat_serializer #(
    parameter int unsigned STACK_DEPTH = 64
) (
    input  logic        clk,
    input  logic        aresetn,
    input  logic [16:0] root_d,
    output logic        root_r,
    output logic [15:0] rd_addr,
    output logic        rd_valid,
    input  logic        rd_ready,
    input  logic [65:0] rd_data,
    input  logic        rd_data_valid,
    output logic [65:0] o_tdata,
    output logic        o_tlast,
    output logic        o_tvalid,
    input  logic        o_tready,
    output logic        err
);

    localparam int unsigned PTR_W   = 16;
    localparam int unsigned WORD_W  = 66;
    localparam int unsigned CHILD_W = 4 * PTR_W;
    localparam int unsigned NEXT_W  = 3;
    localparam int unsigned IDX_W   = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int unsigned SP_W    = $clog2(STACK_DEPTH) + 1;

    localparam logic [1:0]        TAG_NODE  = 2'd2;
    localparam logic [SP_W-1:0]   SP_FULL   = SP_W'(STACK_DEPTH);
    localparam logic [SP_W-1:0]   SP_ONE    = SP_W'(1);
    localparam logic [WORD_W-1:0] NODE_BEAT = {64'd0, TAG_NODE};

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        WAIT    = 3'd2,
        DESCEND = 3'd3,
        EMIT    = 3'd4,
        ERROR   = 3'd5
    } state_e;

    state_e              state_q, state_d;
    logic [SP_W-1:0]     sp_q, sp_d;
    logic                root_r_q, root_r_d;
    logic                rd_valid_q, rd_valid_d;
    logic [PTR_W-1:0]    rd_addr_q, rd_addr_d;
    logic                o_tvalid_q, o_tvalid_d;
    logic [WORD_W-1:0]   o_tdata_q, o_tdata_d;
    logic                o_tlast_q, o_tlast_d;
    logic                err_q, err_d;

    // Frame storage: four child pointers plus the index of the next child to visit.
    logic [CHILD_W-1:0]  ptr_mem  [STACK_DEPTH];
    logic [NEXT_W-1:0]   next_mem [STACK_DEPTH];

    logic                push_c;
    logic                bump_c;
    logic [IDX_W-1:0]    top_idx_c;
    logic [IDX_W-1:0]    push_idx_c;
    logic [NEXT_W-1:0]   top_next_c;
    logic [CHILD_W-1:0]  top_ptrs_c;
    logic [PTR_W-1:0]    top_child_c;
    logic                rd_is_node_c;

    assign top_idx_c    = IDX_W'(sp_q - SP_ONE);
    assign push_idx_c   = IDX_W'(sp_q);
    assign top_next_c   = next_mem[top_idx_c];
    assign top_ptrs_c   = ptr_mem[top_idx_c];
    assign top_child_c  = top_ptrs_c[{top_next_c[1:0], 4'd0} +: PTR_W];
    assign rd_is_node_c = (rd_data[1:0] == TAG_NODE);

    // State register and registered outputs.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q    <= IDLE;
            sp_q       <= '0;
            root_r_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_addr_q  <= '0;
            o_tvalid_q <= 1'b0;
            o_tdata_q  <= '0;
            o_tlast_q  <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            sp_q       <= sp_d;
            root_r_q   <= root_r_d;
            rd_valid_q <= rd_valid_d;
            rd_addr_q  <= rd_addr_d;
            o_tvalid_q <= o_tvalid_d;
            o_tdata_q  <= o_tdata_d;
            o_tlast_q  <= o_tlast_d;
            err_q      <= err_d;
        end
    end

    // Frame contents need no reset: sp_q alone decides which frames are live.
    always_ff @(posedge clk) begin
        if (push_c) begin
            ptr_mem[push_idx_c]  <= rd_data[WORD_W-1:2];
            next_mem[push_idx_c] <= '0;
        end else if (bump_c) begin
            next_mem[top_idx_c]  <= top_next_c + NEXT_W'(1);
        end
    end

    // Next-state and next-output logic; handshake outputs follow the next state.
    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        rd_addr_d = rd_addr_q;
        o_tdata_d = o_tdata_q;
        o_tlast_d = o_tlast_q;
        err_d     = err_q;
        push_c    = 1'b0;
        bump_c    = 1'b0;

        case (state_q)
            IDLE: begin
                if (root_r_q && root_d[0]) begin
                    rd_addr_d = root_d[16:1];
                    state_d   = FETCH;
                end
            end
            FETCH: begin
                if (rd_ready) begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (rd_data_valid) begin
                    if (!rd_is_node_c) begin
                        o_tdata_d = rd_data;
                        o_tlast_d = (sp_q == '0);
                        state_d   = EMIT;
                    end else if (sp_q == SP_FULL) begin
                        err_d   = 1'b1;
                        sp_d    = '0;
                        state_d = ERROR;
                    end else begin
                        push_c  = 1'b1;
                        sp_d    = sp_q + SP_ONE;
                        state_d = DESCEND;
                    end
                end
            end
            DESCEND: begin
                if (!top_next_c[2]) begin
                    rd_addr_d = top_child_c;
                    bump_c    = 1'b1;
                    state_d   = FETCH;
                end else begin
                    sp_d      = sp_q - SP_ONE;
                    o_tdata_d = NODE_BEAT;
                    o_tlast_d = (sp_q == SP_ONE);
                    state_d   = EMIT;
                end
            end
            EMIT: begin
                if (o_tready) begin
                    o_tdata_d = '0;
                    o_tlast_d = 1'b0;
                    state_d   = (sp_q != '0) ? DESCEND : IDLE;
                end
            end
            ERROR: begin
                state_d = ERROR;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        root_r_d   = (state_d == IDLE);
        rd_valid_d = (state_d == FETCH);
        o_tvalid_d = (state_d == EMIT);
    end

    assign root_r   = root_r_q;
    assign rd_addr  = rd_addr_q;
    assign rd_valid = rd_valid_q;
    assign o_tdata  = o_tdata_q;
    assign o_tlast  = o_tlast_q;
    assign o_tvalid = o_tvalid_q;
    assign err      = err_q;

endmodule

// File: tb/tb_qtree_nat_serializer.sv
// Bench for qtree_nat_serializer: random heaps, a randomised memory/sink, and a
// stack-based postfix reference model of the expected beat stream.
module tb_qtree_nat_serializer;

    localparam int unsigned DEPTH = 64;

    typedef struct packed {
        logic        last;
        logic [65:0] data;
    } beat_t;

    logic        clk = 1'b0;
    logic        aresetn;
    logic [16:0] root_d;
    logic        root_r;
    logic [15:0] rd_addr;
    logic        rd_valid;
    logic        rd_ready;
    logic [65:0] rd_data;
    logic        rd_data_valid;
    logic [65:0] o_tdata;
    logic        o_tlast;
    logic        o_tvalid;
    logic        o_tready;
    logic        err;

    logic [65:0] heap [0:65535];
    beat_t       got_q[$];
    beat_t       exp_q[$];

    int n_checks  = 0;
    int n_fail    = 0;
    int stab_viol = 0;
    int rd_delay  = 0;   // cycles rd_valid must wait for rd_ready; -1 = random
    int lat_min   = 1;
    int lat_max   = 1;
    int otr_mode  = 0;   // 0 always ready, 1 toggle, 2 random

    always #5 clk = ~clk;

    qtree_nat_serializer #(.STACK_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .aresetn       (aresetn),
        .root_d        (root_d),
        .root_r        (root_r),
        .rd_addr       (rd_addr),
        .rd_valid      (rd_valid),
        .rd_ready      (rd_ready),
        .rd_data       (rd_data),
        .rd_data_valid (rd_data_valid),
        .o_tdata       (o_tdata),
        .o_tlast       (o_tlast),
        .o_tvalid      (o_tvalid),
        .o_tready      (o_tready),
        .err           (err)
    );

    // Ready generators for the read port and the stream sink.
    initial begin
        int rd_cnt;
        rd_cnt   = 0;
        rd_ready = 1'b0;
        o_tready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rd_valid) rd_cnt = 0;
            if (rd_delay < 0) rd_ready = 1'($urandom_range(0, 1));
            else              rd_ready = (rd_cnt >= rd_delay);
            if (rd_valid) rd_cnt++;
            case (otr_mode)
                0:       o_tready = 1'b1;
                1:       o_tready = ~o_tready;
                default: o_tready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Heap memory responder with randomised latency.
    initial begin
        logic [15:0] a;
        int          lat;
        rd_data_valid = 1'b0;
        rd_data       = '0;
        forever begin
            @(negedge clk);
            if (aresetn === 1'b1 && rd_valid === 1'b1 && rd_ready === 1'b1) begin
                a = rd_addr;
                @(posedge clk);
                lat = $urandom_range(lat_min, lat_max);
                repeat (lat - 1) @(posedge clk);
                #1;
                rd_data       = heap[a];
                rd_data_valid = 1'b1;
                @(posedge clk);
                #1;
                rd_data_valid = 1'b0;
                rd_data       = '0;
            end
        end
    end

    // Beat collector and hold-while-stalled monitor.
    initial begin
        logic        pend_o, pend_r, hold_l;
        logic [65:0] hold_d;
        logic [15:0] hold_a;
        pend_o = 1'b0;
        pend_r = 1'b0;
        hold_l = 1'b0;
        hold_d = '0;
        hold_a = '0;
        forever begin
            @(negedge clk);
            if (aresetn === 1'b1) begin
                if (o_tvalid && o_tready) got_q.push_back({o_tlast, o_tdata});
                if (pend_o && (!o_tvalid || o_tdata !== hold_d || o_tlast !== hold_l)) stab_viol++;
                if (pend_r && (!rd_valid || rd_addr !== hold_a)) stab_viol++;
                pend_o = o_tvalid && !o_tready;
                pend_r = rd_valid && !rd_ready;
                hold_d = o_tdata;
                hold_l = o_tlast;
                hold_a = rd_addr;
            end else begin
                pend_o = 1'b0;
                pend_r = 1'b0;
            end
        end
    end

    // Reference: reverse of a preorder that visits children 3..0 equals postfix 0..3.
    function automatic void build_expected(input logic [15:0] root);
        logic [15:0] stk[$];
        beat_t       rev[$];
        logic [65:0] w;
        logic [15:0] a;
        logic        first;
        first = 1'b1;
        exp_q.delete();
        stk.push_back(root);
        while (stk.size() > 0) begin
            a = stk.pop_back();
            w = heap[a];
            if (w[1:0] == 2'd2) begin
                rev.push_back({first, 64'd0, 2'd2});
                for (int k = 0; k < 4; k++) stk.push_back(w[2+16*k +: 16]);
            end else begin
                rev.push_back({first, w});
            end
            first = 1'b0;
        end
        while (rev.size() > 0) exp_q.push_back(rev.pop_back());
    endfunction

    task automatic gen_tree(input logic [15:0] base, input int maxd, input int pnode);
        logic [15:0] q_a[$];
        int          q_d[$];
        logic [15:0] nxt, a;
        logic [65:0] w;
        int          d, t;
        nxt = base + 16'd1;
        q_a.push_back(base);
        q_d.push_back(0);
        while (q_a.size() > 0) begin
            a = q_a.pop_front();
            d = q_d.pop_front();
            if (d < maxd && $urandom_range(0, 99) < pnode) begin
                w = {64'd0, 2'd2};
                for (int k = 0; k < 4; k++) begin
                    w[2+16*k +: 16] = nxt;
                    q_a.push_back(nxt);
                    q_d.push_back(d + 1);
                    nxt = nxt + 16'd1;
                end
            end else begin
                w = {$urandom, $urandom, 2'd0};
                t = $urandom_range(0, 2);
                w[1:0] = (t == 0) ? 2'd0 : (t == 1) ? 2'd1 : 2'd3;
            end
            heap[a] = w;
        end
    endtask

    task automatic run_stream(input string name, input logic [15:0] root, input int budget);
        int cyc, n;
        got_q.delete();
        build_expected(root);
        cyc = 0;
        while (root_r !== 1'b1 && cyc < budget) begin
            @(posedge clk); #1; cyc++;
        end
        root_d = {root, 1'b1};
        @(posedge clk); #1;
        root_d = '0;
        while (got_q.size() < exp_q.size() && cyc < budget) begin
            @(posedge clk); cyc++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (got_q.size() != exp_q.size()) begin
            n_fail++;
            $display("FAIL %s beat_count got %0d expected %0d", name, got_q.size(), exp_q.size());
        end
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            n_checks++;
            if (got_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL %s beat[%0d] got last=%0b data=%h expected last=%0b data=%h",
                         name, i, got_q[i].last, got_q[i].data, exp_q[i].last, exp_q[i].data);
            end
        end
        n_checks++;
        if (root_r !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_after got root_r=%b expected 1", name, root_r);
        end
    endtask

    task automatic test_reset();
        aresetn = 1'b0;
        root_d  = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({root_r, rd_valid, o_tvalid, o_tlast, err} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got %b expected 00000", {root_r, rd_valid, o_tvalid, o_tlast, err});
        end
        n_checks++;
        if ({rd_addr, o_tdata} !== 82'd0) begin
            n_fail++;
            $display("FAIL reset_data got addr=%h tdata=%h expected 0", rd_addr, o_tdata);
        end
        @(posedge clk); #1;
        aresetn = 1'b1;
        @(negedge clk);
        n_checks++;
        if (root_r !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_cycle got root_r=%b expected 0", root_r);
        end
        @(negedge clk);
        n_checks++;
        if (root_r !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_root_r_rise got %b expected 1", root_r);
        end
    endtask

    task automatic test_single_leaf();
        logic [65:0] w;
        w = {48'd0, 16'h002A, 2'b01};
        heap[16'h0010] = w;
        lat_min = 1; lat_max = 1; rd_delay = 0; otr_mode = 0;
        got_q.delete();
        @(posedge clk); #1;
        root_d = {16'h0010, 1'b1};
        @(negedge clk);
        n_checks++;
        if (root_r !== 1'b1) begin
            n_fail++; $display("FAIL leaf_root_r got %b expected 1", root_r);
        end
        @(posedge clk); #1;
        root_d = '0;
        @(negedge clk);
        n_checks++;
        if (rd_valid !== 1'b1 || rd_addr !== 16'h0010 || root_r !== 1'b0) begin
            n_fail++;
            $display("FAIL leaf_fetch got valid=%b addr=%h root_r=%b expected 1 0010 0", rd_valid, rd_addr, root_r);
        end
        @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b0) begin
            n_fail++; $display("FAIL leaf_early_tvalid got %b expected 0", o_tvalid);
        end
        @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b1 || o_tdata !== w || o_tlast !== 1'b1) begin
            n_fail++;
            $display("FAIL leaf_beat got v=%b d=%h l=%b expected 1 %h 1", o_tvalid, o_tdata, o_tlast, w);
        end
        repeat (2) @(negedge clk);
        n_checks++;
        if (o_tvalid !== 1'b0 || root_r !== 1'b1 || got_q.size() != 1) begin
            n_fail++;
            $display("FAIL leaf_done got v=%b root_r=%b beats=%0d expected 0 1 1", o_tvalid, root_r, got_q.size());
        end
    endtask

    task automatic test_fixed_node();
        beat_t ref_b[5];
        heap[16'h0100] = {16'h0104, 16'h0103, 16'h0102, 16'h0101, 2'd2};
        heap[16'h0101] = {48'd0, 16'd1, 2'd1};
        heap[16'h0102] = 66'd0;
        heap[16'h0103] = {48'd0, 16'd3, 2'd1};
        heap[16'h0104] = {64'd0, 2'd3};
        ref_b[0] = {1'b0, 48'd0, 16'd1, 2'd1};
        ref_b[1] = {1'b0, 66'd0};
        ref_b[2] = {1'b0, 48'd0, 16'd3, 2'd1};
        ref_b[3] = {1'b0, 64'd0, 2'd3};
        ref_b[4] = {1'b1, 64'd0, 2'd2};
        lat_min = 1; lat_max = 2; rd_delay = 0; otr_mode = 0;
        run_stream("fixed_node", 16'h0100, 400);
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= got_q.size() || got_q[i] !== ref_b[i]) begin
                n_fail++;
                $display("FAIL fixed_node_const[%0d] got %h expected %h", i,
                         (i < got_q.size()) ? got_q[i] : beat_t'(0), ref_b[i]);
            end
        end
    endtask

    task automatic test_stall();
        gen_tree(16'h0300, 2, 100);
        stab_viol = 0;
        lat_min = 1; lat_max = 2; rd_delay = 3; otr_mode = 1;
        run_stream("stall_tree", 16'h0300, 3000);
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++; $display("FAIL stall_hold got %0d violations expected 0", stab_viol);
        end
    endtask

    task automatic test_random();
        string nm;
        stab_viol = 0;
        lat_min = 1; lat_max = 4; rd_delay = -1; otr_mode = 2;
        for (int i = 0; i < 6; i++) begin
            gen_tree(16'h1000 + 16'(i * 16'h0200), 3, 45);
            nm = $sformatf("random_tree%0d", i);
            run_stream(nm, 16'h1000 + 16'(i * 16'h0200), 6000);
        end
        n_checks++;
        if (stab_viol != 0) begin
            n_fail++; $display("FAIL random_hold got %0d violations expected 0", stab_viol);
        end
    endtask

    task automatic test_full_depth();
        for (int i = 0; i < DEPTH; i++) begin
            heap[16'h5000 + 16'(i)] = {16'h5F00, 16'h5F01, 16'h5F00,
                                       (i < DEPTH - 1) ? 16'h5000 + 16'(i + 1) : 16'h5F01, 2'd2};
        end
        heap[16'h5F00] = {62'd7, 2'd1, 2'd1};
        heap[16'h5F01] = {64'd0, 2'd0};
        lat_min = 1; lat_max = 1; rd_delay = 0; otr_mode = 0;
        run_stream("full_depth", 16'h5000, 20000);
        n_checks++;
        if (err !== 1'b0) begin
            n_fail++; $display("FAIL full_depth_err got %b expected 0", err);
        end
    endtask

    task automatic test_overflow();
        int cyc;
        for (int i = 0; i <= DEPTH; i++) begin
            heap[16'h4000 + 16'(i)] = {16'h4F00, 16'h4F00, 16'h4F00,
                                       (i < DEPTH) ? 16'h4000 + 16'(i + 1) : 16'h4F00, 2'd2};
        end
        heap[16'h4F00] = {64'd5, 2'd1};
        lat_min = 1; lat_max = 2; rd_delay = 0; otr_mode = 0;
        got_q.delete();
        @(posedge clk); #1;
        root_d = {16'h4000, 1'b1};
        @(posedge clk); #1;
        root_d = '0;
        cyc = 0;
        while (err !== 1'b1 && cyc < 3000) begin
            @(posedge clk); #1; cyc++;
        end
        n_checks++;
        if (err !== 1'b1) begin
            n_fail++; $display("FAIL overflow_err got %b expected 1 (timeout)", err);
        end
        root_d = {16'h0010, 1'b1};
        repeat (20) @(negedge clk);
        root_d = '0;
        n_checks++;
        if (got_q.size() != 0) begin
            n_fail++; $display("FAIL overflow_beats got %0d expected 0", got_q.size());
        end
        n_checks++;
        if ({err, root_r, rd_valid, o_tvalid} !== 4'b1000) begin
            n_fail++;
            $display("FAIL overflow_hold got err/root_r/rd_valid/tvalid=%b expected 1000",
                     {err, root_r, rd_valid, o_tvalid});
        end
    endtask

    task automatic test_reset_mid_wait();
        int cyc;
        @(posedge clk); #1;
        aresetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        aresetn = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (root_r !== 1'b1 || err !== 1'b0) begin
            n_fail++; $display("FAIL recover got root_r=%b err=%b expected 1 0", root_r, err);
        end
        lat_min = 3; lat_max = 3; rd_delay = 0; otr_mode = 0;
        @(posedge clk); #1;
        root_d = {16'h0100, 1'b1};
        @(posedge clk); #1;
        root_d = '0;
        cyc = 0;
        @(negedge clk);
        while (!(rd_valid === 1'b1 && rd_ready === 1'b1) && cyc < 100) begin
            @(negedge clk); cyc++;
        end
        @(posedge clk); #2;
        aresetn = 1'b0;
        #1;
        n_checks++;
        if ({root_r, rd_valid, o_tvalid, o_tlast, err} !== 5'b0 || {rd_addr, o_tdata} !== 82'd0) begin
            n_fail++;
            $display("FAIL midwait_reset got ctrl=%b addr=%h tdata=%h expected 0",
                     {root_r, rd_valid, o_tvalid, o_tlast, err}, rd_addr, o_tdata);
        end
        repeat (5) @(posedge clk);
        #1;
        aresetn = 1'b1;
        got_q.delete();
        cyc = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rd_valid !== 1'b0) cyc++;
        end
        n_checks++;
        if (cyc != 0 || got_q.size() != 0) begin
            n_fail++;
            $display("FAIL midwait_quiet got rd_valid_cycles=%0d beats=%0d expected 0 0", cyc, got_q.size());
        end
        lat_min = 1; lat_max = 3;
        run_stream("after_reset", 16'h0100, 400);
    endtask

    initial begin
        aresetn = 1'b0;
        root_d  = '0;
        test_reset();
        test_single_leaf();
        test_fixed_node();
        test_stall();
        test_random();
        test_full_depth();
        test_overflow();
        test_reset_mid_wait();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/qtree_nat_serializer.md
QTREE_NAT_SERIALIZER -- requirements
Module: qtree_nat_serializer

Interface
REQ-001 SHALL have parameter STACK_DEPTH, default 64, maximum traversal depth in frames (power of two, at most 256).
REQ-002 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-003 SHALL have port aresetn, input, 1; reset is asynchronous and active-low.
REQ-004 SHALL have root_d, input, 17: [16:1] root heap address, [0] valid.
REQ-005 SHALL have root_r, output, 1: root accepted when root_d[0]=1 and root_r=1.
REQ-006 SHALL have rd_addr, output, 16: heap read address.
REQ-007 SHALL have rd_valid, output, 1 and rd_ready, input, 1: read request handshake.
REQ-008 SHALL have rd_data, input, 66 and rd_data_valid, input, 1: read response, no backpressure, arriving 1 or more cycles after the request is accepted.
REQ-009 SHALL have o_tdata, output, 66; o_tlast, output, 1; o_tvalid, output, 1; o_tready, input, 1: AXI-stream node output.
REQ-010 SHALL have err, output, 1: sticky stack overflow flag.

Function
REQ-011 Heap word: [1:0] tag (0 QNone, 1 QVal, 2 QNode, 3 QError); QVal payload [17:2]; QNode child k pointer at [17+16k:2+16k], k=0..3.
REQ-012 Stream order SHALL be postfix: a QNode beat follows all beats of child0, child1, child2, child3 subtrees, in that order.
REQ-013 Leaf beats (tag 0/1/3) SHALL carry the heap word unchanged; QNode beats SHALL carry tag 2 with [65:2] zero.
REQ-014 o_tlast SHALL be 1 only on the root's beat.
REQ-015 FSM states SHALL be IDLE, FETCH, WAIT, DESCEND, EMIT, ERROR.
REQ-016 IDLE: root_r=1; on acceptance, latch the address and go to FETCH; root_r=0 in every other state.
REQ-017 FETCH: rd_valid=1 with rd_addr stable until rd_ready; on acceptance go to WAIT; one outstanding read maximum.
REQ-018 WAIT: on rd_data_valid with a leaf tag go to EMIT with that word; with QNode, push frame {four pointers, next=0} and go to DESCEND.
REQ-019 DESCEND: top frame next<4 -> FETCH child[next], next+=1; next==4 -> pop, EMIT QNode beat.
REQ-020 EMIT: o_tvalid=1, o_tdata/o_tlast stable until o_tready; on transfer go to DESCEND if stack non-empty, else IDLE.
REQ-021 Latency: root accepted in cycle N -> rd_valid=1 in cycle N+1; leaf response in cycle M -> o_tvalid=1 in cycle M+1.
REQ-022 Push with STACK_DEPTH frames occupied SHALL set err=1, drop the stack, emit nothing further, and enter ERROR; ERROR holds root_r=0 until reset.
REQ-023 Stack pointer SHALL be ceil(log2(STACK_DEPTH))+1 bits wide, so full and empty are distinct with no wrap.
REQ-024 rd_data_valid outside WAIT SHALL be ignored.

Reset
REQ-025 Asynchronous aresetn=0 SHALL force IDLE, stack empty, err=0, rd_valid=0, o_tvalid=0, o_tlast=0, o_tdata=0, rd_addr=0 and root_r=0; root_r rises the first cycle after release.
REQ-026 Reset mid-traversal SHALL abandon the traversal; no beat or read issues until a new root is accepted.

Verification
REQ-027 Root 0x0010 holds QVal 0x002A -> one beat, tdata={0x002A,tag 1}, tlast=1, back to IDLE.
REQ-028 Root QNode with children QVal 1, QNone, QVal 3, QError -> beats tag1/val1, tag0, tag1/val3, tag3, tag2 (tlast=1 only on the last).
REQ-029 Two-level tree with o_tready toggling every cycle and rd_ready delayed 3 cycles -> identical beat sequence, tdata stable while stalled.
REQ-030 Chain of STACK_DEPTH+1 nested QNodes -> err=1, no further beats, root_r=0 until reset.
REQ-031 aresetn pulse during WAIT -> all outputs 0; next root yields a correct full stream.
